// File: rtl/wb_switch_pkg.sv
// Shared types, widths and helpers for the parametrised Wishbone bus switch.
package wb_switch_pkg;

    localparam int unsigned WB_ADR_W  = 32;
    localparam int unsigned WB_DAT_W  = 32;
    localparam int unsigned WB_SEL_W  = 4;
    localparam int unsigned ERR_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    // Index width for n slaves; never narrower than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = 32'(i + 1);
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
        return (c == '1) ? c : c + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/wb_addr_decoder.sv
// Combinational base/mask address decoder; lowest matching slave index wins.
module wb_addr_decoder
    import wb_switch_pkg::*;
#(
    parameter int unsigned               N_SLAVES = 7,
    parameter int unsigned               IDX_W    = 3,
    parameter logic [N_SLAVES*32-1:0]    SLV_BASE = {N_SLAVES{32'h0}},
    parameter logic [N_SLAVES*32-1:0]    SLV_MASK = {N_SLAVES{32'h0}}
) (
    input  logic [WB_ADR_W-1:0] adr,
    output logic                hit,
    output logic [IDX_W-1:0]    idx
);

    // Scan from the top down so the lowest index overwrites higher matches.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = int'(N_SLAVES) - 1; i >= 0; i--) begin
            if ((adr & SLV_MASK[WB_ADR_W*i +: WB_ADR_W]) ==
                (SLV_BASE[WB_ADR_W*i +: WB_ADR_W] & SLV_MASK[WB_ADR_W*i +: WB_ADR_W])) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/wb_bus_switch_n.sv
// Registered single-master, N-slave Wishbone switch with address decode,
// timeout/unmapped error termination and debug error tracking.
module wb_bus_switch_n
    import wb_switch_pkg::*;
#(
    parameter int unsigned            N_SLAVES       = 7,
    parameter logic [N_SLAVES*32-1:0] SLV_BASE       = {N_SLAVES{32'h0}},
    parameter logic [N_SLAVES*32-1:0] SLV_MASK       = {N_SLAVES{32'h0}},
    parameter int unsigned            TIMEOUT_CYCLES = 255
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           master_stb_i,
    input  logic                           master_we_i,
    input  logic [WB_ADR_W-1:0]            master_adr_i,
    input  logic [WB_DAT_W-1:0]            master_dat_i,
    input  logic [WB_SEL_W-1:0]            master_sel_i,
    output logic [WB_DAT_W-1:0]            master_dat_o,
    output logic                           master_ack_o,
    output logic                           master_err_o,
    output logic [N_SLAVES-1:0]            slv_cyc_o,
    output logic [N_SLAVES-1:0]            slv_stb_o,
    output logic                           slv_we_o,
    output logic [WB_ADR_W-1:0]            slv_adr_o,
    output logic [WB_DAT_W-1:0]            slv_dat_o,
    output logic [WB_SEL_W-1:0]            slv_sel_o,
    input  logic [N_SLAVES*WB_DAT_W-1:0]   slv_dat_i,
    input  logic [N_SLAVES-1:0]            slv_ack_i,
    output logic [ERR_CNT_W-1:0]           err_count_o,
    output logic [WB_ADR_W-1:0]            last_err_adr_o
);

    localparam int unsigned IDX_W   = clog2(N_SLAVES);
    localparam int unsigned TO_W    = 16;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t                 state;
    logic [IDX_W-1:0]       idx_q;
    logic [TO_W-1:0]        tcnt;
    logic [ERR_CNT_W-1:0]   err_cnt_q;
    logic                   dec_hit;
    logic [IDX_W-1:0]       dec_idx;
    logic                   sel_ack_c;
    logic [WB_DAT_W-1:0]    sel_dat_c;

    assign err_count_o = err_cnt_q;

    wb_addr_decoder #(
        .N_SLAVES (N_SLAVES),
        .IDX_W    (IDX_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .adr (master_adr_i),
        .hit (dec_hit),
        .idx (dec_idx)
    );

    // Route the latched slave's ack and read data; other slaves are ignored.
    always_comb begin
        sel_ack_c = 1'b0;
        sel_dat_c = '0;
        for (int i = 0; i < int'(N_SLAVES); i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_ack_c = slv_ack_i[i];
                sel_dat_c = slv_dat_i[WB_DAT_W*i +: WB_DAT_W];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            idx_q          <= '0;
            tcnt           <= '0;
            err_cnt_q      <= '0;
            master_dat_o   <= '0;
            master_ack_o   <= 1'b0;
            master_err_o   <= 1'b0;
            slv_cyc_o      <= '0;
            slv_stb_o      <= '0;
            slv_we_o       <= 1'b0;
            slv_adr_o      <= '0;
            slv_dat_o      <= '0;
            slv_sel_o      <= '0;
            last_err_adr_o <= '0;
        end else begin
            master_ack_o <= 1'b0;
            master_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (master_stb_i) begin
                        if (dec_hit) begin
                            idx_q     <= dec_idx;
                            slv_we_o  <= master_we_i;
                            slv_adr_o <= master_adr_i;
                            slv_dat_o <= master_dat_i;
                            slv_sel_o <= master_sel_i;
                            slv_cyc_o <= N_SLAVES'(1) << dec_idx;
                            slv_stb_o <= N_SLAVES'(1) << dec_idx;
                            tcnt      <= '0;
                            state     <= BUSY;
                        end else begin
                            master_err_o   <= 1'b1;
                            last_err_adr_o <= master_adr_i;
                            err_cnt_q      <= sat_inc(err_cnt_q);
                            state          <= ERR;
                        end
                    end
                end
                BUSY: begin
                    // Abort beats ack, ack beats timeout.
                    if (!master_stb_i) begin
                        slv_cyc_o <= '0;
                        slv_stb_o <= '0;
                        state     <= IDLE;
                    end else if (sel_ack_c) begin
                        if (!slv_we_o) master_dat_o <= sel_dat_c;
                        slv_cyc_o    <= '0;
                        slv_stb_o    <= '0;
                        master_ack_o <= 1'b1;
                        state        <= RESP;
                    end else if (tcnt == TO_LAST) begin
                        slv_cyc_o      <= '0;
                        slv_stb_o      <= '0;
                        master_err_o   <= 1'b1;
                        last_err_adr_o <= slv_adr_o;
                        err_cnt_q      <= sat_inc(err_cnt_q);
                        state          <= ERR;
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end
                RESP:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_bus_switch_n.sv
// Directed, table-driven bench for wb_bus_switch_n with 3 slaves and an 8-cycle timeout.
module tb_wb_bus_switch_n;

    localparam int unsigned NS = 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          master_stb_i;
    logic          master_we_i;
    logic [31:0]   master_adr_i;
    logic [31:0]   master_dat_i;
    logic [3:0]    master_sel_i;
    logic [31:0]   master_dat_o;
    logic          master_ack_o;
    logic          master_err_o;
    logic [NS-1:0] slv_cyc_o;
    logic [NS-1:0] slv_stb_o;
    logic          slv_we_o;
    logic [31:0]   slv_adr_o;
    logic [31:0]   slv_dat_o;
    logic [3:0]    slv_sel_o;
    logic [NS*32-1:0] slv_dat_i;
    logic [NS-1:0] slv_ack_i;
    logic [15:0]   err_count_o;
    logic [31:0]   last_err_adr_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    wb_bus_switch_n #(
        .N_SLAVES       (NS),
        .SLV_BASE       ({32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .SLV_MASK       ({3{32'hF000_0000}}),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .master_stb_i   (master_stb_i),
        .master_we_i    (master_we_i),
        .master_adr_i   (master_adr_i),
        .master_dat_i   (master_dat_i),
        .master_sel_i   (master_sel_i),
        .master_dat_o   (master_dat_o),
        .master_ack_o   (master_ack_o),
        .master_err_o   (master_err_o),
        .slv_cyc_o      (slv_cyc_o),
        .slv_stb_o      (slv_stb_o),
        .slv_we_o       (slv_we_o),
        .slv_adr_o      (slv_adr_o),
        .slv_dat_o      (slv_dat_o),
        .slv_sel_o      (slv_sel_o),
        .slv_dat_i      (slv_dat_i),
        .slv_ack_i      (slv_ack_i),
        .err_count_o    (err_count_o),
        .last_err_adr_o (last_err_adr_o)
    );

    // ack_at: strobed cycle (1-based) in which ack_bits are driven, 0 = never.
    // exp_resp: sample index (1 = first cycle after the request edge) of ack/err.
    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          ack_at;
        logic [2:0]  ack_bits;
        logic [95:0] rd;
        logic [2:0]  exp_stb;
        int          exp_resp;
        int          exp_ack;
        int          exp_err;
        logic [31:0] exp_dat;
        logic [15:0] exp_cnt;
        logic [31:0] exp_last;
    } vec_t;

    vec_t vecs[7];
    vec_t sat[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int resp_at;
        int acks;
        int errs;
        string tag;
        tag = $sformatf("v%0d", n);
        resp_at = 0;
        acks = 0;
        errs = 0;
        @(negedge clk_i);
        master_stb_i = 1'b1;
        master_we_i  = v.we;
        master_adr_i = v.adr;
        master_dat_i = v.dat;
        master_sel_i = v.sel;
        slv_dat_i    = v.rd;
        slv_ack_i    = '0;
        for (int s = 1; s <= 20; s++) begin
            @(posedge clk_i);
            #1;
            if (s == 1) begin
                chk({tag, "_stb"}, 32'(slv_stb_o), 32'(v.exp_stb));
                chk({tag, "_cyc"}, 32'(slv_cyc_o), 32'(v.exp_stb));
                if (v.exp_stb != 3'b000) begin
                    chk({tag, "_slv_adr"}, slv_adr_o, v.adr);
                    chk({tag, "_slv_we"}, 32'(slv_we_o), 32'(v.we));
                    chk({tag, "_slv_dat"}, slv_dat_o, v.dat);
                    chk({tag, "_slv_sel"}, 32'(slv_sel_o), 32'(v.sel));
                end
            end
            if (master_ack_o) acks++;
            if (master_err_o) errs++;
            if ((master_ack_o || master_err_o) && resp_at == 0) begin
                resp_at = s;
                chk({tag, "_stb_drop"}, 32'(slv_stb_o), 32'd0);
                master_stb_i = 1'b0;
            end
            slv_ack_i = (s == v.ack_at) ? v.ack_bits : 3'b000;
        end
        chk({tag, "_resp_at"}, 32'(resp_at), 32'(v.exp_resp));
        chk({tag, "_acks"}, 32'(acks), 32'(v.exp_ack));
        chk({tag, "_errs"}, 32'(errs), 32'(v.exp_err));
        chk({tag, "_mdat"}, master_dat_o, v.exp_dat);
        chk({tag, "_cnt"}, 32'(err_count_o), 32'(v.exp_cnt));
        chk({tag, "_last"}, last_err_adr_o, v.exp_last);
    endtask

    initial begin
        int pulses;
        vecs[0] = '{1'b0, 32'h1000_0010, 32'h0, 4'hF, 2, 3'b010,
                    {32'h2222_2222, 32'hDEAD_BEEF, 32'h0}, 3'b010, 3, 1, 0,
                    32'hDEAD_BEEF, 16'd0, 32'h0};
        vecs[1] = '{1'b1, 32'h2000_0004, 32'h1234_5678, 4'b0011, 1, 3'b100,
                    {32'hFFFF_FFFF, 32'h0, 32'h0}, 3'b100, 2, 1, 0,
                    32'hDEAD_BEEF, 16'd0, 32'h0};
        vecs[2] = '{1'b0, 32'h5000_0000, 32'h0, 4'hF, 0, 3'b000,
                    96'h0, 3'b000, 1, 0, 1,
                    32'hDEAD_BEEF, 16'd1, 32'h5000_0000};
        vecs[3] = '{1'b0, 32'h0000_0100, 32'h0, 4'hF, 0, 3'b000,
                    96'h0, 3'b001, 9, 0, 1,
                    32'hDEAD_BEEF, 16'd2, 32'h0000_0100};
        vecs[4] = '{1'b0, 32'h0000_0040, 32'h0, 4'hF, 1, 3'b101,
                    {32'hBAD2_2222, 32'h1111_1111, 32'h600D_0000}, 3'b001, 2, 1, 0,
                    32'h600D_0000, 16'd2, 32'h0000_0100};
        vecs[5] = '{1'b0, 32'h1000_0020, 32'h0, 4'hF, 1, 3'b101,
                    {32'hBAD2_2222, 32'h1111_1111, 32'h600D_0000}, 3'b010, 9, 0, 1,
                    32'h600D_0000, 16'd3, 32'h1000_0020};
        vecs[6] = '{1'b0, 32'h2000_0008, 32'h0, 4'hF, 3, 3'b100,
                    {32'hCAFE_F00D, 32'h0, 32'h0}, 3'b100, 4, 1, 0,
                    32'hCAFE_F00D, 16'd3, 32'h1000_0020};
        sat[0] = '{1'b0, 32'h5000_0000, 32'h0, 4'hF, 0, 3'b000, 96'h0, 3'b000, 1, 0, 1,
                   32'h0, 16'hFFFE, 32'h5000_0000};
        sat[1] = '{1'b0, 32'h7000_0000, 32'h0, 4'hF, 0, 3'b000, 96'h0, 3'b000, 1, 0, 1,
                   32'h0, 16'hFFFF, 32'h7000_0000};
        sat[2] = '{1'b0, 32'hF000_0004, 32'h0, 4'hF, 0, 3'b000, 96'h0, 3'b000, 1, 0, 1,
                   32'h0, 16'hFFFF, 32'hF000_0004};

        rst_i        = 1'b1;
        master_stb_i = 1'b0;
        master_we_i  = 1'b0;
        master_adr_i = '0;
        master_dat_i = '0;
        master_sel_i = '0;
        slv_dat_i    = '0;
        slv_ack_i    = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_stb", 32'(slv_stb_o), 32'd0);
        chk("rst_ack_err", 32'({master_ack_o, master_err_o}), 32'd0);
        chk("rst_cnt", 32'(err_count_o), 32'd0);
        chk("rst_mdat", master_dat_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Abort mid-BUSY with a simultaneous ack: nothing returned, strobes dropped.
        @(negedge clk_i);
        master_stb_i = 1'b1;
        master_we_i  = 1'b0;
        master_adr_i = 32'h1000_0000;
        slv_dat_i    = {32'h0, 32'h5555_5555, 32'h0};
        @(posedge clk_i);
        #1;
        chk("abort_stb_up", 32'(slv_stb_o), 32'b010);
        master_stb_i = 1'b0;
        slv_ack_i    = 3'b010;
        @(posedge clk_i);
        #1;
        chk("abort_stb_drop", 32'(slv_stb_o), 32'd0);
        slv_ack_i = 3'b000;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            pulses += int'(master_ack_o) + int'(master_err_o);
            @(posedge clk_i);
            #1;
        end
        chk("abort_no_resp", 32'(pulses), 32'd0);
        chk("abort_mdat", master_dat_o, 32'hCAFE_F00D);

        // Asynchronous reset while a slave is strobed.
        @(negedge clk_i);
        master_stb_i = 1'b1;
        master_adr_i = 32'h0000_0000;
        @(posedge clk_i);
        #1;
        chk("mid_rst_stb_up", 32'(slv_stb_o), 32'b001);
        #2;
        rst_i = 1'b1;
        #1;
        chk("mid_rst_stb", 32'(slv_stb_o), 32'd0);
        chk("mid_rst_cyc", 32'(slv_cyc_o), 32'd0);
        chk("mid_rst_adr", slv_adr_o, 32'd0);
        chk("mid_rst_mdat", master_dat_o, 32'd0);
        chk("mid_rst_cnt", 32'(err_count_o), 32'd0);
        chk("mid_rst_last", last_err_adr_o, 32'd0);
        master_stb_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;

        // Preload the counter near its ceiling, then saturate it.
        @(negedge clk_i);
        force dut.err_cnt_q = 16'hFFFD;
        #1;
        release dut.err_cnt_q;
        for (int i = 0; i < 3; i++) run_vec(sat[i], 10 + i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
